// File: rtl/cam_stream_emulator.sv
// cam_stream_emulator
// Camera-side transmitter: plays back a frame stored in 16-bit RAM words as a
// camera pixel bus (vclk, hsync, vsync, pixel_data), one byte per vclk period.
// Bus outputs change only on the clk that opens a vclk low phase, so the
// receiver sees them stable on the rising edge of vclk.
// Build macro TEST_PATTERN_EN: when defined, pixel_data carries the low byte of
// the byte index (a ramp) instead of RAM data. mem_addr keeps advancing.
module cam_stream_emulator #(
  parameter int DW        = 15,   // RAM data MSB (16-bit word)
  parameter int AW        = 11,   // RAM word-address MSB
  parameter int ROW_BYTES = 256,  // bytes per active row (even, >= 2)
  parameter int ROWS      = 96,   // active rows per frame (>= 1)
  parameter int DIV       = 2,    // clk cycles per vclk half-period (>= 2)
  parameter int H_BLANK   = 8,    // vclk periods with hsync low between rows
  parameter int V_BLANK   = 16    // vclk periods with vsync low after last row
) (
  input  logic          clk,
  input  logic          reset_sync,
  input  logic          p_trigg,
  output logic          p_done,
  output logic          p_busy,
  output logic [AW:0]   mem_addr,
  input  logic [DW:0]   mem_data,
  output logic          vclk,
  output logic          hsync,
  output logic          vsync,
  output logic [7:0]    pixel_data
);

  // vclk phase counter runs 0 .. 2*DIV-1: low for the first DIV, high for the rest
  localparam int PH_W = $clog2(2 * DIV);
  localparam logic [PH_W-1:0] PH_HIGH_M1 = PH_W'(DIV - 1);
  localparam logic [PH_W-1:0] PH_LAST    = PH_W'(2 * DIV - 1);
  localparam logic [PH_W-1:0] PH_ONE     = PH_W'(1);

  // One counter serves bytes-in-row, H blank and V blank periods
  localparam int CNT_MAX_RB = (ROW_BYTES > H_BLANK) ? ROW_BYTES : H_BLANK;
  localparam int CNT_MAX    = (CNT_MAX_RB > V_BLANK) ? CNT_MAX_RB : V_BLANK;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ROW_END = CNT_W'(ROW_BYTES);
  localparam logic [CNT_W-1:0] CNT_HB_END  = CNT_W'(H_BLANK);
  localparam logic [CNT_W-1:0] CNT_VB_END  = CNT_W'(V_BLANK);

  localparam int ROW_W = $clog2(ROWS + 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  localparam logic [AW+1:0] A_ONE = {{(AW + 1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEAD = 3'd1,
    S_ROW  = 3'd2,
    S_HBLK = 3'd3,
    S_VBLK = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Pick the byte of a RAM word addressed by the byte-counter LSB
  function automatic logic [7:0] byte_sel(input logic [15:0] word, input logic hi);
    logic [7:0] b;
    if (hi) begin
      b = word[15:8];
    end else begin
      b = word[7:0];
    end
    return b;
  endfunction

  state_t            r_state;
  logic [PH_W-1:0]   r_ph;
  logic              r_vclk;
  logic              r_hsync;
  logic              r_vsync;
  logic [7:0]        r_pixel;
  logic              r_done;
  logic              r_busy;
  logic [AW:0]       r_mem_addr;
  logic [AW+1:0]     r_a;
  logic [ROW_W-1:0]  r_row;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_trig_pend;
  logic              r_trig_s1;
  logic              r_trig_s2;
  logic              r_trig_s3;

  logic              w_trig_rise;
  logic [7:0]        w_byte;

`ifdef TEST_PATTERN_EN
  logic [AW+9:0]     w_a_ext;
  assign w_a_ext = {8'h00, r_a};
`endif

  assign w_trig_rise = r_trig_s2 & ~r_trig_s3;

  assign p_done     = r_done;
  assign p_busy     = r_busy;
  assign mem_addr   = r_mem_addr;
  assign vclk       = r_vclk;
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign pixel_data = r_pixel;

  // Two-flop synchroniser for the trigger plus a third stage for rising-edge detection
  always_ff @(posedge clk or posedge reset_sync) begin
    if (reset_sync) begin
      r_trig_s1 <= 1'b0;
      r_trig_s2 <= 1'b0;
      r_trig_s3 <= 1'b0;
    end else begin
      r_trig_s1 <= p_trigg;
      r_trig_s2 <= r_trig_s1;
      r_trig_s3 <= r_trig_s2;
    end
  end

  // Byte to show in the next period. RAM data for the word fetched at the
  // start of the previous high phase has settled by the low-phase opening edge.
  always_comb begin
    w_byte = 8'h00;
`ifdef TEST_PATTERN_EN
    w_byte = w_a_ext[7:0];
`else
    w_byte = byte_sel(mem_data[15:0], r_a[0]);
`endif
  end

  // Frame sequencer: vclk phase, counters, fetch address and registered bus outputs
  always_ff @(posedge clk or posedge reset_sync) begin
    if (reset_sync) begin
      r_state     <= S_IDLE;
      r_ph        <= '0;
      r_vclk      <= 1'b0;
      r_hsync     <= 1'b0;
      r_vsync     <= 1'b0;
      r_pixel     <= 8'h00;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_addr  <= '0;
      r_a         <= '0;
      r_row       <= '0;
      r_cnt       <= '0;
      r_trig_pend <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_trig_rise || r_trig_pend) begin
            // This clk opens the low phase of the lead-in period
            r_state     <= S_LEAD;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_vsync     <= 1'b1;
            r_hsync     <= 1'b0;
            r_pixel     <= 8'h00;
            r_vclk      <= 1'b0;
            r_ph        <= '0;
            r_a         <= '0;
            r_row       <= '0;
            r_cnt       <= CNT_ONE;
            r_trig_pend <= 1'b0;
          end else begin
            r_vclk <= 1'b0;
            r_ph   <= '0;
          end
        end

        S_DONE: begin
          // An edge seen on this clk must not be lost while passing through IDLE
          r_state     <= S_IDLE;
          r_trig_pend <= w_trig_rise;
        end

        S_LEAD, S_ROW, S_HBLK, S_VBLK: begin
          if (r_ph != PH_LAST) begin
            r_ph <= r_ph + PH_ONE;
            if (r_ph == PH_HIGH_M1) begin
              // Entering the high phase: present the word holding the next byte
              r_vclk     <= 1'b1;
              r_mem_addr <= r_a[AW+1:1];
            end else begin
              r_vclk <= r_vclk;
            end
          end else begin
            // Period boundary: open the next low phase and update the bus
            r_ph   <= '0;
            r_vclk <= 1'b0;
            case (r_state)
              S_LEAD: begin
                r_state <= S_ROW;
                r_hsync <= 1'b1;
                r_vsync <= 1'b1;
                r_pixel <= w_byte;
                r_a     <= r_a + A_ONE;
                r_cnt   <= CNT_ONE;
              end
              S_ROW: begin
                if (r_cnt == CNT_ROW_END) begin
                  r_hsync <= 1'b0;
                  r_pixel <= 8'h00;
                  r_cnt   <= CNT_ONE;
                  r_row   <= r_row + ROW_ONE;
                  if (r_row == ROW_LAST) begin
                    r_state <= S_VBLK;
                    r_vsync <= 1'b0;
                  end else begin
                    r_state <= S_HBLK;
                    r_vsync <= 1'b1;
                  end
                end else begin
                  r_hsync <= 1'b1;
                  r_vsync <= 1'b1;
                  r_pixel <= w_byte;
                  r_a     <= r_a + A_ONE;
                  r_cnt   <= r_cnt + CNT_ONE;
                end
              end
              S_HBLK: begin
                if (r_cnt == CNT_HB_END) begin
                  r_state <= S_ROW;
                  r_hsync <= 1'b1;
                  r_vsync <= 1'b1;
                  r_pixel <= w_byte;
                  r_a     <= r_a + A_ONE;
                  r_cnt   <= CNT_ONE;
                end else begin
                  r_cnt <= r_cnt + CNT_ONE;
                end
              end
              S_VBLK: begin
                if (r_cnt == CNT_VB_END) begin
                  // Frame complete; vclk parks low and the bus goes quiet
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_hsync <= 1'b0;
                  r_vsync <= 1'b0;
                  r_pixel <= 8'h00;
                  r_cnt   <= '0;
                end else begin
                  r_cnt <= r_cnt + CNT_ONE;
                end
              end
              default: begin
                r_state <= S_IDLE;
              end
            endcase
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_vclk  <= 1'b0;
          r_hsync <= 1'b0;
          r_vsync <= 1'b0;
          r_pixel <= 8'h00;
          r_ph    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_stream_emulator.sv
// tb_cam_stream_emulator
// Directed bench: small frame geometry (4 bytes x 2 rows, DIV=2, H blank 2,
// V blank 3) on one instance, and a narrow-address instance (AW=1, 3 rows)
// to exercise byte-counter wrap.
`timescale 1ns/1ps
module tb_cam_stream_emulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_sync;
  logic        p_trigg;
  logic        p_done, p_busy, vclk, hsync, vsync;
  logic [11:0] mem_addr;
  logic [15:0] mem_data;
  logic [7:0]  pixel_data;

  logic        p_trigg5;
  logic        p_done5, p_busy5, vclk5, hsync5, vsync5;
  logic [1:0]  mem_addr5;
  logic [15:0] mem_data5;
  logic [7:0]  pixel_data5;

  logic [15:0] ram  [0:7];
  logic [15:0] ram5 [0:3];

  int n_vec = 0;
  int n_err = 0;

  cam_stream_emulator #(
    .DW(15), .AW(11), .ROW_BYTES(4), .ROWS(2), .DIV(2), .H_BLANK(2), .V_BLANK(3)
  ) u_dut (
    .clk(clk), .reset_sync(reset_sync), .p_trigg(p_trigg),
    .p_done(p_done), .p_busy(p_busy), .mem_addr(mem_addr), .mem_data(mem_data),
    .vclk(vclk), .hsync(hsync), .vsync(vsync), .pixel_data(pixel_data)
  );

  cam_stream_emulator #(
    .DW(15), .AW(1), .ROW_BYTES(4), .ROWS(3), .DIV(2), .H_BLANK(2), .V_BLANK(3)
  ) u_dut5 (
    .clk(clk), .reset_sync(reset_sync), .p_trigg(p_trigg5),
    .p_done(p_done5), .p_busy(p_busy5), .mem_addr(mem_addr5), .mem_data(mem_data5),
    .vclk(vclk5), .hsync(hsync5), .vsync(vsync5), .pixel_data(pixel_data5)
  );

  // Synchronous RAM models: data for an address appears one clk later
  always @(posedge clk) begin
    mem_data  <= ram[mem_addr[2:0]];
    mem_data5 <= ram5[mem_addr5];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Expected per-period bus {vsync, hsync, pixel} at each vclk rise
  logic [9:0] exp_frm [0:13];
  logic [9:0] cap     [0:31];
  int         n_per;
  int         n_busy;

  task automatic pulse_start();
    @(negedge clk);
    p_trigg = 1'b1;
  endtask

  // Record one frame of u_dut; optionally raise the trigger again at busy-clk rise_at
  task automatic capture1(input bit hold, input int rise_at);
    int   guard;
    logic prev_v;
    n_per  = 0;
    n_busy = 0;
    prev_v = 1'b0;
    guard  = 0;
    for (int i = 0; i < 32; i++) cap[i] = 10'h3FF;
    while (p_busy !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("frame_start", {31'd0, p_busy}, 32'd1);
    while (p_busy === 1'b1 && guard < 300) begin
      n_busy++;
      if (vclk === 1'b1 && prev_v === 1'b0) begin
        if (n_per < 32) cap[n_per] = {vsync, hsync, pixel_data};
        n_per++;
      end
      prev_v = vclk;
      if (!hold && n_busy == 2) p_trigg = 1'b0;
      if (rise_at > 0 && n_busy == rise_at) p_trigg = 1'b1;
      if (rise_at > 0 && rise_at < 50 && n_busy == rise_at + 3) p_trigg = 1'b0;
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic check_frame(input string tag);
    chk($sformatf("%s_periods", tag), n_per, 32'd14);
    chk($sformatf("%s_busy_clks", tag), n_busy, 32'd56);
    for (int i = 0; i < 14; i++)
      chk($sformatf("%s_p%0d", tag, i), {22'd0, cap[i]}, {22'd0, exp_frm[i]});
    chk($sformatf("%s_done", tag), {29'd0, p_done, p_busy, vclk}, 32'b100);
    chk($sformatf("%s_idle_bus", tag), {22'd0, vsync, hsync, pixel_data}, 32'd0);
  endtask

  // Count busy clks over a window where no frame may start
  task automatic quiet_window(input string tag, input int clks);
    int nb;
    nb = 0;
    for (int i = 0; i < clks; i++) begin
      @(negedge clk);
      if (p_busy === 1'b1) nb++;
    end
    chk(tag, nb, 32'd0);
  endtask

  logic [7:0] exp_px5 [0:11];
  logic [1:0] exp_ad5 [0:12];

  initial begin
    int guard;
    int n5;
    int nb5;
    logic pv5;
    logic [7:0] px5 [0:15];
    logic [1:0] ad5 [0:15];

    ram[0] = 16'hBBAA; ram[1] = 16'hDDCC; ram[2] = 16'h2211; ram[3] = 16'h4433;
    ram[4] = 16'h0000; ram[5] = 16'h0000; ram[6] = 16'h0000; ram[7] = 16'h0000;
    ram5[0] = 16'hBBAA; ram5[1] = 16'hDDCC; ram5[2] = 16'h2211; ram5[3] = 16'h4433;

    exp_frm[0]  = 10'h200;
    exp_frm[1]  = 10'h3AA; exp_frm[2]  = 10'h3BB; exp_frm[3]  = 10'h3CC; exp_frm[4]  = 10'h3DD;
    exp_frm[5]  = 10'h200; exp_frm[6]  = 10'h200;
    exp_frm[7]  = 10'h311; exp_frm[8]  = 10'h322; exp_frm[9]  = 10'h333; exp_frm[10] = 10'h344;
    exp_frm[11] = 10'h000; exp_frm[12] = 10'h000; exp_frm[13] = 10'h000;

    exp_px5 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44,
                8'hAA, 8'hBB, 8'hCC, 8'hDD};
    exp_ad5 = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3,
                2'd0, 2'd0, 2'd1, 2'd1, 2'd2};

    // Reset state
    reset_sync = 1'b1;
    p_trigg    = 1'b0;
    p_trigg5   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {26'd0, p_done, p_busy, vclk, hsync, vsync, |pixel_data}, 32'd0);
    chk("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
    reset_sync = 1'b0;
    repeat (3) @(negedge clk);

    // Scenario 1: basic frame
    pulse_start();
    capture1(1'b0, 0);
    check_frame("t1");
    repeat (4) @(negedge clk);

    // Scenario 2: second edge mid-row is ignored
    pulse_start();
    capture1(1'b0, 10);
    check_frame("t2");
    quiet_window("t2_no_restart", 20);

    // Edge landing in V blank is ignored too
    pulse_start();
    capture1(1'b0, 46);
    check_frame("t2v");
    quiet_window("t2v_no_restart", 20);
    chk("t2v_done_held", {31'd0, p_done}, 32'd1);

    // Edge arriving on the DONE clk starts the next frame from IDLE
    pulse_start();
    capture1(1'b0, 55);
    check_frame("tdc");
    @(negedge clk);
    chk("tdc_idle_clk", {31'd0, p_busy}, 32'd0);
    @(negedge clk);
    chk("tdc_restart", {31'd0, p_busy}, 32'd1);
    p_trigg = 1'b0;
    capture1(1'b0, 0);
    check_frame("tdc2");
    repeat (4) @(negedge clk);

    // Scenario 3: reset during third byte of row 0
    pulse_start();
    guard = 0;
    while (p_busy !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    p_trigg = 1'b0;
    repeat (13) @(negedge clk);
    chk("t3_pre_reset", {23'd0, hsync, pixel_data}, {23'd0, 1'b1, 8'hCC});
    #1 reset_sync = 1'b1;
    #1;
    chk("t3_async_drop", {26'd0, p_done, p_busy, vclk, hsync, vsync, |pixel_data}, 32'd0);
    @(negedge clk);
    reset_sync = 1'b0;
    repeat (2) @(negedge clk);
    pulse_start();
    capture1(1'b0, 0);
    check_frame("t3");
    repeat (4) @(negedge clk);

    // Scenario 4: trigger held high across DONE plays exactly one frame
    pulse_start();
    capture1(1'b1, 0);
    check_frame("t4");
    quiet_window("t4_held_no_retrig", 30);
    p_trigg = 1'b0;
    repeat (4) @(negedge clk);
    pulse_start();
    capture1(1'b0, 0);
    check_frame("t4b");

    // Scenario 5: narrow address, byte counter wraps after 8 bytes
    @(negedge clk);
    p_trigg5 = 1'b1;
    guard = 0;
    while (p_busy5 !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("t5_start", {31'd0, p_busy5}, 32'd1);
    n5  = 0;
    nb5 = 0;
    pv5 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      px5[i] = 8'h00;
      ad5[i] = 2'd0;
    end
    while (p_busy5 === 1'b1 && guard < 300) begin
      nb5++;
      if (nb5 == 2) p_trigg5 = 1'b0;
      if (vclk5 === 1'b1 && pv5 === 1'b0 && hsync5 === 1'b1) begin
        if (n5 < 16) begin
          px5[n5] = pixel_data5;
          ad5[n5] = mem_addr5;
        end
        n5++;
      end
      pv5 = vclk5;
      @(negedge clk);
      guard++;
    end
    chk("t5_bytes", n5, 32'd12);
    chk("t5_busy_clks", nb5, 32'd80);
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("t5_px%0d", k), {24'd0, px5[k]}, {24'd0, exp_px5[k]});
      chk($sformatf("t5_addr%0d", k), {30'd0, ad5[k]}, {30'd0, exp_ad5[k + 1]});
    end
    chk("t5_done", {31'd0, p_done5}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cam_stream_emulator.md
Name: cam_stream_emulator

Overview:
- Camera-side transmitter: plays back a frame held in 16-bit RAM as a camera pixel bus (vclk, hsync, vsync, pixel_data).
- Output is sampled on the rising edge of vclk, the same convention the capture path uses.
- Used for loopback self-test of the capture path and for feeding stored images to downstream logic without a sensor.
- Sits between the image RAM read port and the camera input pins of the capture path; the CPU starts it with a trigger.

Parameters:
- DW, 15, RAM data MSB (16-bit word).
- AW, 11, RAM word-address MSB.
- ROW_BYTES, 256, bytes per active row (even, ≥2).
- ROWS, 96, active rows per frame (≥1).
- DIV, 2, clk cycles per vclk half-period (≥2).
- H_BLANK, 8, vclk periods with hsync low between rows.
- V_BLANK, 16, vclk periods with vsync low after last row.

Ports:
- clk  in  1  system clock
- reset_sync  in  1  asynchronous, active-high reset
- p_trigg  in  1  start request (async; 2-FF synchronised, rising edge detected)
- p_done  out  1  frame played out; held until next start
- p_busy  out  1  frame in progress
- mem_addr  out  AW+1  RAM word address
- mem_data  in  DW+1  RAM read data, valid 1 clk after mem_addr
- vclk  out  1  pixel clock
- hsync  out  1  row valid
- vsync  out  1  frame valid
- pixel_data  out  8  pixel byte

Behaviour:
- Reset, asynchronous: state IDLE; all outputs 0; byte counter 0; row counter 0.
- vclk generator: runs only when p_busy. Low for DIV clk, then high for DIV clk. When idle it is held at 0.
- Phase timing: hsync, vsync and pixel_data change only on the clk that starts a vclk low phase, so they are stable across the rising edge.
- Byte counter A is AW+2 bits, cleared at frame start.
  - mem_addr = A[AW+1:1].
  - A[0]=0 selects mem_data[7:0]; A[0]=1 selects mem_data[15:8].
  - A wraps naturally at 2^(AW+2).
- Fetch: address presented on the first clk of the high phase. Data is registered DIV-1 clk later and driven on the next low-phase start.
- States:
  - IDLE: outputs low. Rising edge of synchronised p_trigg → LEAD; p_done←0, p_busy←1.
  - LEAD: vsync=1, hsync=0 for 1 vclk period → ROW.
  - ROW: vsync=1, hsync=1; one byte per vclk period, A+1 each period. After ROW_BYTES bytes: row counter+1; if rows==ROWS → VBLK, else → HBLK.
  - HBLK: hsync=0, vsync=1, pixel_data=0 for H_BLANK periods → ROW.
  - VBLK: vsync=0, hsync=0 for V_BLANK periods → DONE.
  - DONE: p_done=1, p_busy=0, vclk stops at 0 → IDLE on the same clk.
- p_done stays 1 through IDLE until the next accepted trigger.
- Trigger rules:
  - Triggers while p_busy are ignored, including edges during VBLK.
  - A trigger arriving on the DONE clk is honoured from IDLE on the next clk.
  - A level-held p_trigg does not retrigger; a new rising edge is required.
- Reset mid-frame: outputs drop to 0 immediately (asynchronous). No partial p_done.
- First hsync rise coincides with vsync=1, so the receiver sees vs=hs=1 at frame start.

Optional Feature:
- TEST_PATTERN_EN
  - Defined: pixel_data = A[7:0] (byte-index ramp). mem_data is ignored, but mem_addr still advances.
  - Undefined: pixel_data comes from RAM as described above.

Test Plan:
1. ROW_BYTES=4, ROWS=2, DIV=2, H_BLANK=2, V_BLANK=3; RAM word0=16'hBBAA, word1=16'hDDCC, word2=16'h2211, word3=16'h4433; pulse p_trigg.
   - Required: bytes AA,BB,CC,DD on rising vclk with hsync=1, then 2 periods hsync=0, then 11,22,33,44.
   - Required: 3 periods vsync=0, then p_done=1.
   - Required: total active+blank = 1+4+2+4+3 = 14 vclk periods = 56 clk.
2. Same setup, second p_trigg edge mid-row → ignored; byte sequence and p_done timing identical to scenario 1.
3. Assert reset_sync during the third byte of row 0 → vclk, hsync, vsync, pixel_data, p_busy all 0 within the same clk; re-trigger gives a clean frame starting at AA.
4. p_trigg held high across DONE → exactly one frame played; releasing and re-raising p_trigg starts a second identical frame.
5. AW=1, ROW_BYTES=4, ROWS=3 → mem_addr sequence 0,0,1,1,2,2,3,3,0,0,1,1 (wrap).
6. Compile with TEST_PATTERN_EN, ROW_BYTES=4, ROWS=2 → pixel_data 00,01,02,03 then 04,05,06,07 regardless of RAM contents.
